// File: rtl/mips_multicycle_ctrl_if.sv
// Control bus between the multicycle MIPS main FSM and its datapath.
// The controller side (master) receives the opcode and memory handshake and
// drives every select/enable; the datapath side (slave) is the mirror image.
interface mips_multicycle_ctrl_if;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       ext_zero;
    logic       illegal_op;
    logic       mem_timeout;
    logic [3:0] state;

    modport master (
        input  opcode, mem_ready,
        output pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, ext_zero, illegal_op, mem_timeout, state
    );

    modport slave (
        output opcode, mem_ready,
        input  pc_write, pc_write_cond, pc_src, i_or_d, mem_read, mem_write,
               ir_write, reg_dst, mem_to_reg, reg_write, alu_src_a, alu_src_b,
               alu_op, ext_zero, illegal_op, mem_timeout, state
    );
endinterface

// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM of the multicycle MIPS core. Sequences the shared
// ALU/memory datapath one instruction at a time, stalls on mem_ready and
// aborts to FETCH with a sticky flag when a memory access never completes.
// CNT_W must be wide enough that MEM_TIMEOUT fits (2**CNT_W > MEM_TIMEOUT).
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    mips_multicycle_ctrl_if.master bus
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXEC   = 4'd6;
    localparam logic [3:0] S_ALUWB  = 4'd7;
    localparam logic [3:0] S_BRANCH = 4'd8;
    localparam logic [3:0] S_IEXEC  = 4'd9;
    localparam logic [3:0] S_IWB    = 4'd10;
    localparam logic [3:0] S_JUMP   = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;

    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MEM_TIMEOUT);

    logic [3:0]       state_q, state_d;
    logic [5:0]       op_q, op_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             illegal;
    logic             op_is_logic_imm;

    // Raw (ungated) control word decoded from the current state.
    logic       pc_write_r, pc_write_cond_r, i_or_d_r, mem_read_r, mem_write_r;
    logic       ir_write_r, reg_dst_r, mem_to_reg_r, reg_write_r, alu_src_a_r;
    logic [1:0] pc_src_r, alu_src_b_r, alu_op_r;

    assign op_is_logic_imm = (op_q == OP_ANDI) || (op_q == OP_ORI);

    // Next-state, opcode latch and memory watchdog.
    always_comb begin
        state_d       = state_q;
        op_d          = op_q;
        wait_cnt_d    = '0;
        mem_timeout_d = mem_timeout_q;
        illegal       = 1'b0;

        case (state_q)
            S_FETCH:  if (bus.mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                op_d = bus.opcode;
                case (bus.opcode)
                    OP_R:                      state_d = S_EXEC;
                    OP_LW, OP_SW:              state_d = S_MEMADR;
                    OP_BEQ:                    state_d = S_BRANCH;
                    OP_J:                      state_d = S_JUMP;
                    OP_ADDI, OP_ANDI, OP_ORI:  state_d = S_IEXEC;
                    default: begin
                        state_d = S_FETCH;
                        illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  if (bus.mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (bus.mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_ALUWB;
            S_ALUWB:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_IEXEC:  state_d = S_IWB;
            S_IWB:    state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase

        // Every memory-wait state leaves on mem_ready, so the counter only
        // survives while the access is still outstanding; a late mem_ready
        // in the limit cycle still wins over the abort.
        if ((state_q == S_FETCH || state_q == S_MEMRD || state_q == S_MEMWR) && !bus.mem_ready) begin
            if (wait_cnt_q == WAIT_LIMIT) begin
                mem_timeout_d = 1'b1;
                state_d       = S_FETCH;
                wait_cnt_d    = '0;
            end else begin
                wait_cnt_d = wait_cnt_q + 1'b1;
            end
        end
    end

    // State, latched opcode, wait counter and sticky timeout flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_FETCH;
            op_q          <= '0;
            wait_cnt_q    <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    // Moore decode of the control word; only FETCH's IR/PC loads look at mem_ready.
    always_comb begin
        pc_write_r      = 1'b0;
        pc_write_cond_r = 1'b0;
        pc_src_r        = 2'b00;
        i_or_d_r        = 1'b0;
        mem_read_r      = 1'b0;
        mem_write_r     = 1'b0;
        ir_write_r      = 1'b0;
        reg_dst_r       = 1'b0;
        mem_to_reg_r    = 1'b0;
        reg_write_r     = 1'b0;
        alu_src_a_r     = 1'b0;
        alu_src_b_r     = 2'b00;
        alu_op_r        = 2'b00;

        case (state_q)
            S_FETCH: begin
                mem_read_r  = 1'b1;
                alu_src_b_r = 2'b01;
                ir_write_r  = bus.mem_ready;
                pc_write_r  = bus.mem_ready;
            end
            S_DECODE: alu_src_b_r = 2'b11;
            S_MEMADR: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
            end
            S_MEMRD: begin
                i_or_d_r   = 1'b1;
                mem_read_r = 1'b1;
            end
            S_MEMWB: begin
                mem_to_reg_r = 1'b1;
                reg_write_r  = 1'b1;
            end
            S_MEMWR: begin
                i_or_d_r    = 1'b1;
                mem_write_r = 1'b1;
            end
            S_EXEC: begin
                alu_src_a_r = 1'b1;
                alu_op_r    = 2'b10;
            end
            S_ALUWB: begin
                reg_dst_r   = 1'b1;
                reg_write_r = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a_r     = 1'b1;
                alu_op_r        = 2'b01;
                pc_write_cond_r = 1'b1;
                pc_src_r        = 2'b01;
            end
            S_IEXEC: begin
                alu_src_a_r = 1'b1;
                alu_src_b_r = 2'b10;
                alu_op_r    = op_is_logic_imm ? 2'b11 : 2'b00;
            end
            S_IWB:  reg_write_r = 1'b1;
            S_JUMP: begin
                pc_write_r = 1'b1;
                pc_src_r   = 2'b10;
            end
            default: ;
        endcase
    end

    // Outputs are forced low while reset is held so nothing is issued mid-reset.
    assign bus.pc_write      = pc_write_r      & ~rst;
    assign bus.pc_write_cond = pc_write_cond_r & ~rst;
    assign bus.pc_src        = pc_src_r        & {2{~rst}};
    assign bus.i_or_d        = i_or_d_r        & ~rst;
    assign bus.mem_read      = mem_read_r      & ~rst;
    assign bus.mem_write     = mem_write_r     & ~rst;
    assign bus.ir_write      = ir_write_r      & ~rst;
    assign bus.reg_dst       = reg_dst_r       & ~rst;
    assign bus.mem_to_reg    = mem_to_reg_r    & ~rst;
    assign bus.reg_write     = reg_write_r     & ~rst;
    assign bus.alu_src_a     = alu_src_a_r     & ~rst;
    assign bus.alu_src_b     = alu_src_b_r     & {2{~rst}};
    assign bus.alu_op        = alu_op_r        & {2{~rst}};
    // DECODE computes the branch offset, which is always sign-extended.
    assign bus.ext_zero      = op_is_logic_imm & (state_q != S_DECODE) & ~rst;
    assign bus.illegal_op    = illegal         & ~rst;
    assign bus.mem_timeout   = mem_timeout_q   & ~rst;
    assign bus.state         = state_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl. Each driven cycle pushes the
// expected state and control word; the negedge monitor pops and compares.
module tb_mips_multicycle_ctrl;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5;
    localparam int EXEC = 6, ALUWB = 7, BRANCH = 8, IEXEC = 9, IWB = 10, JUMP = 11;

    typedef struct packed {
        logic [3:0]  st;
        logic [19:0] ctl;
    } exp_t;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    bit   to_exp;
    exp_t sb_q[$];

    mips_multicycle_ctrl_if bus ();

    mips_multicycle_ctrl #(.MEM_TIMEOUT(4), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] obs_ctl;
    assign obs_ctl = {1'b0, bus.pc_write, bus.pc_write_cond, bus.pc_src, bus.i_or_d,
                      bus.mem_read, bus.mem_write, bus.ir_write, bus.reg_dst,
                      bus.mem_to_reg, bus.reg_write, bus.alu_src_a, bus.alu_src_b,
                      bus.alu_op, bus.ext_zero, bus.illegal_op, bus.mem_timeout};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Expected control word for a state, written from the state table.
    function automatic logic [19:0] exp_ctl(int st, bit mr, bit ext, bit ill, bit to);
        logic [19:0] v;
        v = '0;
        case (st)
            FETCH:  begin v[13] = 1'b1; v[6:5] = 2'b01; v[11] = mr; v[18] = mr; end
            DECODE: begin v[6:5] = 2'b11; v[1] = ill; end
            MEMADR: begin v[7] = 1'b1; v[6:5] = 2'b10; end
            MEMRD:  begin v[14] = 1'b1; v[13] = 1'b1; end
            MEMWB:  begin v[9] = 1'b1; v[8] = 1'b1; end
            MEMWR:  begin v[14] = 1'b1; v[12] = 1'b1; end
            EXEC:   begin v[7] = 1'b1; v[4:3] = 2'b10; end
            ALUWB:  begin v[10] = 1'b1; v[8] = 1'b1; end
            BRANCH: begin v[7] = 1'b1; v[4:3] = 2'b01; v[17] = 1'b1; v[16:15] = 2'b01; end
            IEXEC:  begin v[7] = 1'b1; v[6:5] = 2'b10; v[4:3] = ext ? 2'b11 : 2'b00; end
            IWB:    v[8] = 1'b1;
            JUMP:   begin v[18] = 1'b1; v[16:15] = 2'b10; end
            default: ;
        endcase
        v[2] = ext;
        v[0] = to;
        return v;
    endfunction

    // One cycle of stimulus plus its expected outcome.
    task automatic drive(input bit rs, input logic [5:0] op, input bit mr,
                         input int st, input bit ext, input bit ill);
        exp_t e;
        @(posedge clk);
        #1;
        rst           = rs;
        bus.opcode    = op;
        bus.mem_ready = mr;
        if (rs) begin
            to_exp = 1'b0;
            e.st   = 4'd0;
            e.ctl  = '0;
        end else begin
            e.st  = 4'(st);
            e.ctl = exp_ctl(st, mr, ext, ill, to_exp);
        end
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            $display("t=%0t rst=%0b st=%0d ctl=%h exp_st=%0d exp_ctl=%h",
                     $time, rst, bus.state, obs_ctl, e.st, e.ctl);
            check("state", {28'd0, bus.state}, {28'd0, e.st});
            check("ctl", {12'd0, obs_ctl}, {12'd0, e.ctl});
        end
    end

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        to_exp        = 1'b0;
        rst           = 1'b1;
        bus.opcode    = '0;
        bus.mem_ready = 1'b0;

        // Reset: everything low, FETCH's mem_read included.
        drive(1, OP_R, 1, FETCH, 0, 0);
        drive(1, OP_R, 1, FETCH, 0, 0);

        // lw with mem_ready held high.
        drive(0, OP_R,  1, FETCH,  0, 0);
        drive(0, OP_LW, 1, DECODE, 0, 0);
        drive(0, OP_R,  1, MEMADR, 0, 0);
        drive(0, OP_R,  1, MEMRD,  0, 0);
        drive(0, OP_R,  1, MEMWB,  0, 0);

        // ori (zero-extend, logical alu_op) followed by addi.
        drive(0, OP_R,    1, FETCH,  0, 0);
        drive(0, OP_ORI,  1, DECODE, 0, 0);
        drive(0, OP_R,    1, IEXEC,  1, 0);
        drive(0, OP_R,    1, IWB,    1, 0);
        drive(0, OP_R,    1, FETCH,  1, 0);
        drive(0, OP_ADDI, 1, DECODE, 0, 0);
        drive(0, OP_R,    1, IEXEC,  0, 0);
        drive(0, OP_R,    1, IWB,    0, 0);

        // sw with three stalled cycles in MEMWR.
        drive(0, OP_R,  1, FETCH,  0, 0);
        drive(0, OP_SW, 1, DECODE, 0, 0);
        drive(0, OP_R,  1, MEMADR, 0, 0);
        drive(0, OP_R,  0, MEMWR,  0, 0);
        drive(0, OP_R,  0, MEMWR,  0, 0);
        drive(0, OP_R,  0, MEMWR,  0, 0);
        drive(0, OP_R,  1, MEMWR,  0, 0);

        // R-type, beq, j.
        drive(0, OP_R,   1, FETCH,  0, 0);
        drive(0, OP_R,   1, DECODE, 0, 0);
        drive(0, OP_R,   1, EXEC,   0, 0);
        drive(0, OP_R,   1, ALUWB,  0, 0);
        drive(0, OP_R,   1, FETCH,  0, 0);
        drive(0, OP_BEQ, 1, DECODE, 0, 0);
        drive(0, OP_R,   1, BRANCH, 0, 0);
        drive(0, OP_R,   1, FETCH,  0, 0);
        drive(0, OP_J,   1, DECODE, 0, 0);
        drive(0, OP_R,   1, JUMP,   0, 0);

        // Illegal opcode: one-cycle pulse, straight back to FETCH.
        drive(0, OP_R,   1, FETCH,  0, 0);
        drive(0, OP_BAD, 1, DECODE, 0, 1);
        drive(0, OP_R,   0, FETCH,  0, 0);

        // FETCH stall reaching the limit; mem_ready in the limit cycle wins.
        drive(0, OP_R, 0, FETCH,  0, 0);
        drive(0, OP_R, 0, FETCH,  0, 0);
        drive(0, OP_R, 0, FETCH,  0, 0);
        drive(0, OP_R, 1, FETCH,  0, 0);
        drive(0, OP_J, 1, DECODE, 0, 0);
        drive(0, OP_R, 1, JUMP,   0, 0);

        // Watchdog in MEMRD: abort after the fifth wait cycle, flag sticks.
        drive(0, OP_R,  1, FETCH,  0, 0);
        drive(0, OP_LW, 1, DECODE, 0, 0);
        drive(0, OP_R,  1, MEMADR, 0, 0);
        for (int i = 0; i < 5; i++) drive(0, OP_R, 0, MEMRD, 0, 0);
        to_exp = 1'b1;
        drive(0, OP_R, 1, FETCH,  0, 0);
        drive(0, OP_J, 1, DECODE, 0, 0);
        drive(0, OP_R, 1, JUMP,   0, 0);
        drive(0, OP_R, 1, FETCH,  0, 0);

        // Reset during MEMWB clears everything including the timeout flag.
        drive(0, OP_LW, 1, DECODE, 0, 0);
        drive(0, OP_R,  1, MEMADR, 0, 0);
        drive(0, OP_R,  1, MEMRD,  0, 0);
        drive(0, OP_R,  1, MEMWB,  0, 0);
        drive(1, OP_R,  1, FETCH,  0, 0);
        drive(0, OP_R,  0, FETCH,  0, 0);
        drive(0, OP_R,  1, FETCH,  0, 0);

        // Reset during an ori clears the latched opcode (ext_zero drops).
        drive(0, OP_ORI, 1, DECODE, 0, 0);
        drive(0, OP_R,   1, IEXEC,  1, 0);
        drive(1, OP_R,   1, FETCH,  0, 0);
        drive(0, OP_R,   0, FETCH,  0, 0);

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        if (sb_q.size() > 0) check("drain", sb_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
